// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transaction state encoding, default clock
// frequencies and the bit-time / quarter constants derived from them.
package i2c_pkg;

    localparam int unsigned SYS_FREQ = 40_000_000;
    localparam int unsigned I2C_FREQ = 100_000;
    localparam int unsigned BIT_CLKS = SYS_FREQ / I2C_FREQ;   // clk per SCL period
    localparam int unsigned QTR_CLKS = BIT_CLKS / 4;          // clk per quarter
    localparam int unsigned CNT_W    = $clog2(BIT_CLKS);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE_ADDR,
        ST_ACK_1,
        ST_WRITE_DATA,
        ST_READ_DATA,
        ST_ACK_2,
        ST_MASTER_ACK,
        ST_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_phase_gen.sv
// Bit-time quarter counter.
//   clk, rst      : clock, async active-high reset
//   en_i          : counter runs while high, is held at 0 while low
//   cnt_o         : current position 0..BIT_CLKS-1 inside the bit-time
//   pulse_nxt_c_o : quarter (0..3) the counter will be in after the next edge
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int unsigned BITS_PER = BIT_CLKS,
    parameter int unsigned W        = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [1:0]   pulse_nxt_c_o
);

    localparam int unsigned QTR = BITS_PER / 4;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Wrap once per bit-time; idle forces the count back to zero.
    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == W'(BITS_PER - 1)) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o         = cnt_q;
    assign pulse_nxt_c_o = 2'(cnt_d / W'(QTR));

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master (one write or one read per request).
//   clk, rst : clock, async active-high reset
//   newd     : start request, honoured only when idle
//   addr, op : 7-bit target address and R/W bit (1 = read)
//   din      : byte to write
//   scl, sda : I2C bus (sda open-drain style: driven or released)
//   dout     : last byte read
//   busy     : transaction in progress
//   ack_err  : target NACKed an ACK slot of the last transaction
//   done     : one-clk pulse at the end of each transaction
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned sys_freq = SYS_FREQ,
    parameter int unsigned i2c_freq = I2C_FREQ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic [6:0] addr,
    input  logic       op,
    input  logic [7:0] din,
    output logic       scl,
    inout  wire        sda,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ack_err,
    output logic       done
);

    localparam int unsigned BITS = sys_freq / i2c_freq;
    localparam int unsigned QTR  = BITS / 4;
    localparam int unsigned W    = $clog2(BITS);

    i2c_state_e state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_addr_q, tx_addr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;
    logic       scl_q, scl_d;
    logic       sda_en_q, sda_en_d;
    logic       sda_t_q, sda_t_d;

    logic [W-1:0] cnt;
    logic [1:0]   pulse_nxt;
    logic         sda_in;
    logic         sample;
    logic         last;

    i2c_phase_gen #(.BITS_PER(BITS), .W(W)) u_phase (
        .clk           (clk),
        .rst           (rst),
        .en_i          (busy_q),
        .cnt_o         (cnt),
        .pulse_nxt_c_o (pulse_nxt)
    );

    assign sda    = sda_en_q ? sda_t_q : 1'bz;
    assign sda_in = sda;
    assign sample = (cnt == W'(2 * QTR));
    assign last   = (cnt == W'(BITS - 1));

    // Next state plus bus outputs; outputs are computed for the state and
    // quarter of the coming cycle so the registered pins line up exactly.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        tx_addr_d = tx_addr_q;
        tx_data_d = tx_data_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        scl_d     = 1'b1;
        sda_en_d  = 1'b0;
        sda_t_d   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (newd) begin
                    state_d   = ST_START;
                    tx_addr_d = {addr, op};
                    tx_data_d = din;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    bit_d     = 3'd0;
                end
            end
            ST_START: begin
                if (last) state_d = ST_WRITE_ADDR;
            end
            ST_WRITE_ADDR: begin
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_ACK_1;
                end
            end
            ST_ACK_1: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (last) begin
                    if (ack_err_q)         state_d = ST_STOP;
                    else if (tx_addr_q[0]) state_d = ST_READ_DATA;
                    else                   state_d = ST_WRITE_DATA;
                end
            end
            ST_WRITE_DATA: begin
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_ACK_2;
                end
            end
            ST_ACK_2: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (last) state_d = ST_STOP;
            end
            ST_READ_DATA: begin
                if (sample) rx_d = {rx_q[6:0], sda_in};
                if (last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_MASTER_ACK;
                        dout_d  = rx_q;
                    end
                end
            end
            ST_MASTER_ACK: begin
                if (last) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE: begin
                scl_d    = 1'b1;
                sda_en_d = 1'b0;
                sda_t_d  = 1'b1;
            end
            ST_START: begin
                scl_d    = 1'b1;
                sda_en_d = 1'b1;
                sda_t_d  = (pulse_nxt < 2'd2);
            end
            ST_STOP: begin
                scl_d    = (pulse_nxt != 2'd0);
                sda_en_d = 1'b1;
                sda_t_d  = (pulse_nxt == 2'd3);
            end
            default: begin
                scl_d = pulse_nxt[1];
                if (pulse_nxt == 2'd0) begin
                    // SDA only moves mid-way through the SCL low phase.
                    sda_en_d = sda_en_q;
                    sda_t_d  = sda_t_q;
                end else if (state_d == ST_WRITE_ADDR) begin
                    sda_en_d = 1'b1;
                    sda_t_d  = tx_addr_d[3'd7 - bit_d];
                end else if (state_d == ST_WRITE_DATA) begin
                    sda_en_d = 1'b1;
                    sda_t_d  = tx_data_d[3'd7 - bit_d];
                end else if (state_d == ST_MASTER_ACK) begin
                    sda_en_d = 1'b1;
                    sda_t_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_q     <= 3'd0;
            tx_addr_q <= 8'h00;
            tx_data_q <= 8'h00;
            rx_q      <= 8'h00;
            dout_q    <= 8'h00;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_en_q  <= 1'b0;
            sda_t_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            tx_addr_q <= tx_addr_d;
            tx_data_q <= tx_data_d;
            rx_q      <= rx_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_en_q  <= sda_en_d;
            sda_t_q   <= sda_t_d;
        end
    end

    assign scl     = scl_q;
    assign dout    = dout_q;
    assign busy    = busy_q;
    assign ack_err = ack_err_q;
    assign done    = done_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a bit-time schedule model of the expected bus,
// a target that answers from that schedule, and a bus monitor that
// decodes the bits actually seen on SCL rising edges.
module tb_i2c_master;

    localparam int BT = 400;
    localparam int K_START = 0, K_MST = 1, K_TGT = 2, K_STOP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       newd;
    logic [6:0] addr;
    logic       op;
    logic [7:0] din;
    logic       scl;
    wire        sda_w;
    logic [7:0] dout;
    logic       busy;
    logic       ack_err;
    logic       done;

    logic tgt_low = 1'b0;
    pullup (sda_w);
    assign sda_w = tgt_low ? 1'b0 : 1'bz;

    i2c_master dut (
        .clk(clk), .rst(rst), .newd(newd), .addr(addr), .op(op), .din(din),
        .scl(scl), .sda(sda_w), .dout(dout), .busy(busy),
        .ack_err(ack_err), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model of the transaction in flight.
    int         cyc = 0;
    int         tacc = 0;
    logic       active = 1'b0;
    logic       checking = 1'b0;
    int         nbt = 0;
    int         kind [0:19];
    logic       val  [0:19];
    logic       m_op = 1'b0, m_nack = 1'b0;
    logic [7:0] m_rd = 8'h00;
    logic       m_ack_prev = 1'b0;
    logic [7:0] m_dout_prev = 8'h00;
    logic [7:0] mem [0:127];

    bit   mon_q [$];
    logic prev_scl = 1'b1, prev_sda = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Line level the target pulls low: from quarter 1 of its slot until
    // quarter 1 of the following slot.
    function automatic logic tlow(input int t);
        int slot;
        if (!active || t < 0) return 1'b0;
        slot = ((t % BT) >= 100) ? t / BT : t / BT - 1;
        if (slot < 0 || slot >= nbt) return 1'b0;
        return (kind[slot] == K_TGT) && (val[slot] == 1'b0);
    endfunction

    // Expected {scl, sda, busy, done, ack_err, dout} at cycle t of the transaction.
    function automatic logic [12:0] model_out(input int t);
        logic s_scl, s_sda, s_busy, s_done, s_ack;
        logic [7:0] s_dout;
        int bt, c, q;
        s_scl = 1'b1; s_sda = 1'b1; s_busy = 1'b0; s_done = 1'b0;
        s_ack = m_ack_prev; s_dout = m_dout_prev;
        if (active && t >= 0) begin
            bt = t / BT; c = t % BT; q = c / 100;
            if (bt < nbt) begin
                s_busy = 1'b1;
                if (kind[bt] == K_START) begin
                    s_scl = 1'b1; s_sda = (q < 2);
                end else if (kind[bt] == K_STOP) begin
                    s_scl = (q != 0); s_sda = (q == 3);
                end else begin
                    s_scl = (q >= 2);
                    s_sda = (c >= 100) ? val[bt] : val[bt - 1];
                end
            end
            s_done = (t == nbt * BT);
            s_ack  = m_nack && (t > 9 * BT + 200);
            if (m_op && !m_nack && t >= 18 * BT) s_dout = m_rd;
        end
        return {s_scl, s_sda, s_busy, s_done, s_ack, s_dout};
    endfunction

    function automatic logic [7:0] mon_byte(input int i);
        logic [7:0] b = 8'h00;
        for (int j = 0; j < 8; j++) begin
            b = {b[6:0], (i + j < mon_q.size()) ? logic'(mon_q[i + j]) : 1'b0};
        end
        return b;
    endfunction

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        tgt_low <= tlow(cyc + 1 - tacc);
    end

    // Per-cycle compare, SDA stability check and bus bit capture.
    always @(negedge clk) begin
        logic [12:0] exp, got;
        int t, bt;
        logic in_ss;
        if (!rst && checking) begin
            t   = cyc - tacc;
            exp = model_out(t);
            got = {scl, sda_w, busy, done, ack_err, dout};
            n_chk++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bus t=%0d {scl,sda,busy,done,ack_err,dout}: got=%b_%h expected=%b_%h",
                         t, got[12:8], got[7:0], exp[12:8], exp[7:0]);
            end
            bt    = t / BT;
            in_ss = active && t >= 0 && bt < nbt && (kind[bt] == K_START || kind[bt] == K_STOP);
            if (prev_scl && scl && !in_ss) begin
                n_chk++;
                if (sda_w !== prev_sda) begin
                    n_err++;
                    $display("FAIL sda_stable t=%0d: got=%b expected=%b", t, sda_w, prev_sda);
                end
            end
            if (prev_scl && scl && prev_sda && !sda_w) mon_q.delete();
            else if (!prev_scl && scl) mon_q.push_back(sda_w);
        end
        prev_scl = scl;
        prev_sda = sda_w;
    end

    function automatic logic present(input logic [6:0] a);
        return (a == 7'h12) || (a == 7'h05);
    endfunction

    // Target side: store the data byte of an acknowledged write.
    task automatic target_write();
        logic [7:0] b0;
        b0 = mon_byte(0);
        if (mon_q.size() >= 17 && !b0[0] && present(b0[7:1]) && !mon_q[8])
            mem[b0[7:1]] = mon_byte(9);
    endtask

    task automatic run_txn(input logic [6:0] a, input logic o, input logic [7:0] d,
                           input int stray_at, input int rst_at, output int lat);
        logic pres;
        logic [7:0] ab;
        logic aborted;
        if (active) begin
            m_ack_prev = m_nack;
            if (m_op && !m_nack) m_dout_prev = m_rd;
        end
        active = 1'b0;
        pres = present(a);
        ab   = {a, o};
        m_op = o; m_nack = !pres; m_rd = mem[a];
        kind[0] = K_START; val[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin kind[1 + i] = K_MST; val[1 + i] = ab[7 - i]; end
        kind[9] = K_TGT; val[9] = !pres;
        if (!pres) begin
            kind[10] = K_STOP; val[10] = 1'b1; nbt = 11;
        end else begin
            for (int i = 0; i < 8; i++) begin
                kind[10 + i] = o ? K_TGT : K_MST;
                val[10 + i]  = o ? m_rd[7 - i] : d[7 - i];
            end
            kind[18] = o ? K_MST : K_TGT; val[18] = o;
            kind[19] = K_STOP; val[19] = 1'b1; nbt = 20;
        end
        @(negedge clk);
        addr = a; op = o; din = d; newd = 1'b1;
        tacc = cyc + 1; active = 1'b1;
        @(negedge clk);
        newd = 1'b0; addr = ~a; op = ~o; din = ~d;
        lat = -1; aborted = 1'b0;
        for (int k = 0; k <= nbt * BT + 100; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin lat = k; break; end
            if (k == rst_at) begin aborted = 1'b1; break; end
            if (k == stray_at) begin newd = 1'b1; addr = 7'h40; op = 1'b1; din = 8'hFF; end
            if (k == stray_at + 1) newd = 1'b0;
        end
        if (lat < 0 && !aborted) begin
            n_chk++; n_err++;
            $display("FAIL done_timeout: got=none expected=done within %0d clk", nbt * BT + 100);
        end
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[5] = 8'h05;
        rst = 1'b1; newd = 1'b0; addr = 7'h00; op = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_scl", 32'(scl), 1);
        check("reset_sda", 32'(sda_w), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ack_err", 32'(ack_err), 0);
        check("reset_dout", 32'(dout), 0);
        rst = 1'b0; checking = 1'b1;
        repeat (5) @(negedge clk);

        run_txn(7'h12, 1'b0, 8'hA5, -1, -1, lat);
        check("wr_latency", lat, 8000);
        check("wr_addr_byte", mon_byte(0), 8'h24);
        check("wr_data_byte", mon_byte(9), 8'hA5);
        target_write();
        check("wr_mem", mem[7'h12], 8'hA5);
        check("wr_ack_err", 32'(ack_err), 0);
        repeat (20) @(negedge clk);

        run_txn(7'h05, 1'b1, 8'h00, -1, -1, lat);
        check("rd_latency", lat, 8000);
        check("rd_addr_byte", mon_byte(0), 8'h0B);
        check("rd_data_byte", mon_byte(9), 8'h05);
        check("rd_master_nack", 32'(mon_q.size() > 17 ? mon_q[17] : 1'b0), 1);
        check("rd_dout", 32'(dout), 8'h05);
        check("rd_ack_err", 32'(ack_err), 0);
        repeat (20) @(negedge clk);

        run_txn(7'h40, 1'b0, 8'h77, -1, -1, lat);
        check("nack_latency", lat, 4400);
        check("nack_ack_err", 32'(ack_err), 1);
        check("nack_bits_on_bus", mon_q.size(), 10);
        check("nack_addr_byte", mon_byte(0), 8'h80);
        check("nack_dout_kept", 32'(dout), 8'h05);
        repeat (20) @(negedge clk);

        run_txn(7'h12, 1'b0, 8'h3C, 1000, -1, lat);
        check("stray_latency", lat, 8000);
        check("stray_addr_byte", mon_byte(0), 8'h24);
        check("stray_data_byte", mon_byte(9), 8'h3C);
        check("stray_ack_err", 32'(ack_err), 0);
        target_write();
        check("stray_mem", mem[7'h12], 8'h3C);
        repeat (20) @(negedge clk);

        run_txn(7'h12, 1'b0, 8'h5A, -1, 14 * BT + 150, lat);
        #2;
        rst = 1'b1; active = 1'b0; m_ack_prev = 1'b0; m_dout_prev = 8'h00;
        #1;
        check("midrst_scl", 32'(scl), 1);
        check("midrst_sda", 32'(sda_w), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_dout", 32'(dout), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);

        run_txn(7'h12, 1'b0, 8'hC3, -1, -1, lat);
        check("post_rst_latency", lat, 8000);
        check("post_rst_data_byte", mon_byte(9), 8'hC3);
        target_write();
        check("post_rst_mem", mem[7'h12], 8'hC3);
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter: sys_freq, default 40000000, system clock frequency in Hz.
REQ-002 Parameter: i2c_freq, default 100000, SCL frequency in Hz; one bit-time = sys_freq/i2c_freq = 400 clk, split into 4 quarters (pulse 0..3) of 100 clk each.
REQ-003 Port: clk  input  1  system clock; the block uses this single clock, rising edge only.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: newd  input  1  start-transaction request, sampled only in idle.
REQ-006 Port: addr  input  7  7-bit target address.
REQ-007 Port: op  input  1  1 = read, 0 = write; sent as the R/W bit.
REQ-008 Port: din  input  8  write data byte.
REQ-009 Port: scl  output  1  I2C clock, driven by the master.
REQ-010 Port: sda  inout  1  I2C data; driven with sda_t when sda_en=1, else high-Z.
REQ-011 Port: dout  output  8  byte received in a read.
REQ-012 Port: busy  output  1  high from newd acceptance until the stop condition completes.
REQ-013 Port: ack_err  output  1  high if any target ACK slot read 1 (NACK).
REQ-014 Port: done  output  1  one-clk pulse at end of every transaction.

Function
REQ-015 States: idle, start, write_addr, ack_1, write_data, read_data, ack_2, master_ack, stop.
REQ-016 Quarter counter: count 0..399 wraps per bit-time; pulse = count/100; counter held at 0 in idle.
REQ-017 idle: scl=1, sda released; on newd=1 latch {addr,op} into an 8-bit shift register, latch din, set busy, clear ack_err, enter start.
REQ-018 start (1 bit-time): scl=1 all quarters; sda driven 1 in pulses 0-1 and 0 in pulses 2-3.
REQ-019 Data bits: scl=0 in pulses 0-1, 1 in pulses 2-3; the master changes SDA at count==100, and every receiver samples SDA at count==200.
REQ-020 write_addr: 8 bits MSB first ({addr,op}); bit counter 0..7, increments at count==399.
REQ-021 ack_1: sda released; sample at count==200; NACK -> ack_err=1, go to stop; ACK -> op=0: write_data, op=1: read_data.
REQ-022 write_data: 8 bits of latched din MSB first, then ack_2.
REQ-023 ack_2: sda released; NACK sets ack_err=1; always go to stop.
REQ-024 read_data: sda released; shift sampled bits MSB first into a shift register; load dout at end of bit 7.
REQ-025 master_ack: master drives sda=1 (NACK, single-byte read) for one bit-time, then stop.
REQ-026 stop (1 bit-time): pulse 0 scl=0 sda=0; pulses 1-2 scl=1 sda=0; pulse 3 scl=1 sda=1; at count==399 go to idle, clear busy, pulse done for exactly 1 clk.
REQ-027 Write transaction length = 20 bit-times (8000 clk) from newd acceptance to done; a read is also 20 bit-times.
REQ-028 newd while busy is ignored; addr/op/din changes after acceptance have no effect.
REQ-029 ack_err holds its value until the next accepted newd.
REQ-030 dout holds its value until the next completed read; writes leave it unchanged.

Reset
REQ-031 rst asserted at any time, including mid-transaction: state=idle, counter=0, bit counter=0, scl=1, sda_en=0, sda_t=1, busy=0, done=0, ack_err=0, dout=8'h00.
REQ-032 After rst deasserts, the block waits in idle; any partial transfer is abandoned.

Structure
REQ-033 Package i2c_pkg: state enum type, sys_freq/i2c_freq defaults, derived bit-time and quarter constants; this enum is shared with the target block.
REQ-034 Sub-module i2c_phase_gen: quarter counter and pulse output, enabled by busy.

Verification
REQ-035 Write: addr=7'h12, op=0, din=8'hA5 with an ACKing target model -> SDA bytes 8'h24 then 8'hA5; target mem[0x12]=8'hA5; done 1 clk at 8000 clk; ack_err=0.
REQ-036 Read: addr=7'h05, op=1, target returns 8'h05 -> address byte 8'h0B; dout=8'h05; master NACK (sda=1) in ACK slot; ack_err=0.
REQ-037 Address NACK: no target at 7'h40 -> ack_err=1; no data byte; stop follows ack_1; done asserted.
REQ-038 rst pulse during bit 4 of write_data -> scl=1, sda high-Z, busy=0 within 1 clk, no done; next newd completes normally.
REQ-039 newd re-asserted with different addr while busy -> ignored; bus shows only the first transaction; ack_err cleared on the next accepted newd.
REQ-040 Protocol checker: SDA never changes while scl=1 except in the start and stop states.
